// File: rtl/layer_1_pkg.sv
// layer_1_pkg: shared widths, threshold/leak defaults and saturating add for the spiking layer.
package layer_1_pkg;
  localparam int W = 8;
  localparam int ACC_W = 16;
  localparam int THRESH = 128;
  localparam int LEAK_SHIFT = 3;
  localparam int FRAC_BITS = 7;
  function automatic int sat_add(input int a, input int b, input int width);
    longint s, hi, lo;
    hi = (longint'(1) << (width - 1)) - 1;
    lo = -(longint'(1) << (width - 1));
    s = longint'(a) + longint'(b);
    return int'(s > hi ? hi : s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/layer_1_lif_neuron.sv
// lif_neuron: one integrate-and-fire neuron with saturating membrane; leak enabled by LAYER_1_LEAK_EN.
module lif_neuron
  import layer_1_pkg::sat_add;
#(
  parameter int N_IN = 5,
  parameter int W = layer_1_pkg::W,
  parameter int ACC_W = layer_1_pkg::ACC_W,
  parameter int THRESH = layer_1_pkg::THRESH,
  parameter int LEAK_SHIFT = layer_1_pkg::LEAK_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse,
  input  logic [N_IN-1:0]   pixel,
  input  logic [W*N_IN-1:0] weights,
  input  logic [W-1:0]      bias,
  output logic              spike
);
  localparam int IW = W + $clog2(N_IN + 1);
  localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);
  logic signed [IW-1:0] cur;
  logic signed [ACC_W-1:0] v, v_base, v_next;
  logic fire;
  always_comb begin
    cur = IW'($signed(bias));
    for (int i = 0; i < N_IN; i++)
      cur = pixel[i] ? cur + IW'($signed(weights[W*i +: W])) : cur;
  end
`ifdef LAYER_1_LEAK_EN
  assign v_base = v - (v >>> LEAK_SHIFT);
`else
  assign v_base = v;
`endif
  assign v_next = ACC_W'(sat_add(int'(v_base), int'(cur), ACC_W));
  assign fire = v_next >= TH;
  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      spike <= 1'b0;
    end else if (pulse) begin
      v <= fire ? '0 : v_next;
      spike <= fire;
    end else begin
      spike <= 1'b0;
    end
  end
endmodule

// File: rtl/layer_1.sv
// layer_1: fully connected first SNN layer of N_OUT LIF neurons; optional leak via LAYER_1_LEAK_EN.
module layer_1 #(
  parameter int N_IN = 5,
  parameter int N_OUT = 2,
  parameter int W = layer_1_pkg::W,
  parameter int ACC_W = layer_1_pkg::ACC_W,
  parameter int THRESH = layer_1_pkg::THRESH,
  parameter int LEAK_SHIFT = layer_1_pkg::LEAK_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pulse,
  input  logic [N_IN-1:0]         L_1_pexel,
  input  logic [W*N_IN*N_OUT-1:0] L_1_weights,
  input  logic [W*N_OUT-1:0]      L_1_bias,
  output logic [N_OUT-1:0]        spike
);
  for (genvar n = 0; n < N_OUT; n++) begin : g_n
    lif_neuron #(
      .N_IN(N_IN), .W(W), .ACC_W(ACC_W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .clk(clk),
      .reset(reset),
      .pulse(pulse),
      .pixel(L_1_pexel),
      .weights(L_1_weights[W*N_IN*n +: W*N_IN]),
      .bias(L_1_bias[W*n +: W]),
      .spike(spike[n])
    );
  end
endmodule

// File: tb/tb_layer_1.sv
// tb_layer_1: directed self-checking bench for layer_1 (default build or LAYER_1_LEAK_EN).
module tb_layer_1;
  localparam int N_IN = 5;
  localparam int N_OUT = 2;
  localparam int W = 8;
`ifdef LAYER_1_LEAK_EN
  localparam int BIAS_PERIOD = 6;
`else
  localparam int BIAS_PERIOD = 4;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pulse = 1'b0;
  logic [N_IN-1:0] pix = '0;
  logic [W*N_IN*N_OUT-1:0] wts = '0;
  logic [W*N_OUT-1:0] bias = '0;
  logic [N_OUT-1:0] spike;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  layer_1 dut (
    .clk(clk),
    .reset(reset),
    .pulse(pulse),
    .L_1_pexel(pix),
    .L_1_weights(wts),
    .L_1_bias(bias),
    .spike(spike)
  );

  task automatic set_w(input int n, input logic [W-1:0] val);
    for (int i = 0; i < N_IN; i++) wts[W*(N_IN*n+i) +: W] = val;
  endtask

  task automatic step(input logic p, input logic r);
    @(negedge clk);
    pulse = p;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      total++;
      if (spike !== 2'b00) begin
        bad++;
        $display("FAIL reset cyc%0d: spike=%b expected 00", k, spike);
      end
    end
  endtask

  task automatic test_integrate();
    logic [1:0] exp;
    clear();
    pix = 5'b11111;
    set_w(0, 8'h10);
    set_w(1, 8'h00);
    bias = '0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1);
      exp = (k % 2 == 0) ? 2'b01 : 2'b00;
      total++;
      if (spike !== exp) begin
        bad++;
        $display("FAIL integrate upd%0d: spike=%b expected %b", k, spike, exp);
      end
    end
  endtask

  task automatic test_hold();
    clear();
    step(1'b1, 1'b1);
    total++;
    if (spike !== 2'b00) begin
      bad++;
      $display("FAIL hold first: spike=%b expected 00", spike);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1);
      total++;
      if (spike !== 2'b00) begin
        bad++;
        $display("FAIL hold edge%0d: spike=%b expected 00", k, spike);
      end
    end
    step(1'b1, 1'b1);
    total++;
    if (spike !== 2'b01) begin
      bad++;
      $display("FAIL hold fire: spike=%b expected 01", spike);
    end
  endtask

  task automatic test_bias();
    logic [1:0] exp;
    clear();
    pix = '0;
    bias = {8'h00, 8'h20};
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1);
      exp = (k % BIAS_PERIOD == 0) ? 2'b01 : 2'b00;
      total++;
      if (spike !== exp) begin
        bad++;
        $display("FAIL bias upd%0d: spike=%b expected %b", k, spike, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear();
    pix = 5'b11111;
    set_w(0, 8'h10);
    set_w(1, 8'h00);
    bias = '0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    total++;
    if (spike !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid at reset: spike=%b expected 00", spike);
    end
    step(1'b1, 1'b1);
    total++;
    if (spike !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid upd1: spike=%b expected 00", spike);
    end
    step(1'b1, 1'b1);
    total++;
    if (spike !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid upd2: spike=%b expected 01", spike);
    end
  endtask

  task automatic test_neg_sat();
    clear();
    pix = 5'b11111;
    set_w(0, 8'h00);
    set_w(1, 8'h80);
    bias = {8'h80, 8'h00};
    for (int k = 1; k <= 60; k++) begin
      step(1'b1, 1'b1);
      total++;
      if (spike !== 2'b00) begin
        bad++;
        $display("FAIL neg_sat upd%0d: spike=%b expected 00", k, spike);
      end
    end
`ifndef LAYER_1_LEAK_EN
    // From the clamp at -32768, +762 per update first reaches threshold on update 44.
    set_w(1, 8'h7F);
    bias = {8'h7F, 8'h00};
    for (int k = 1; k <= 44; k++) begin
      step(1'b1, 1'b1);
      total++;
      if (spike !== (k == 44 ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL neg_recover upd%0d: spike=%b expected %b", k, spike, k == 44 ? 2'b10 : 2'b00);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_hold();
    test_bias();
    test_reset_mid();
    test_neg_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
